// File: rtl/int_scheduler_if.sv
// Handshake and source/mask bus between the interrupt scheduler and its controller.
// The slave modport is the scheduler side. The master modport is the controller/stimulus side.
interface int_scheduler_if #(
    parameter int NSRC = 4
);
    logic [NSRC-1:0] src_int;
    logic            mask_we;
    logic [NSRC-1:0] mask_din;
    logic [NSRC-1:0] mask_out;
    logic [NSRC-1:0] pending_out;
    logic            irq;
    logic [7:0]      irq_vec;
    logic [2:0]      irq_src;
    logic            irq_ack;
    logic            irq_done;
    logic            busy;

    modport slave (
        input  src_int, mask_we, mask_din, irq_ack, irq_done,
        output mask_out, pending_out, irq, irq_vec, irq_src, busy
    );

    modport master (
        output src_int, mask_we, mask_din, irq_ack, irq_done,
        input  mask_out, pending_out, irq, irq_vec, irq_src, busy
    );
endinterface

// File: rtl/int_scheduler.sv
// Interrupt scheduler: it synchronises and edge-detects the sources into pending bits, masks them,
// and picks one by priority. It then runs the req/ack/done handshake, with no nesting.
// Optional macro PRIO_ROTATE_EN replaces fixed priority with round-robin priority.
module int_scheduler #(
    parameter int         NSRC       = 4,
    parameter logic [7:0] VEC_BASE   = 8'hF0,
    parameter int         VEC_STRIDE = 2
) (
    input  logic            clk,
    input  logic            rst,
    int_scheduler_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_e;

    state_e          state_q, state_d;
    logic [NSRC-1:0] s1_q, s2_q, s3_q;
    logic [NSRC-1:0] pending_q, pending_d, mask_q, mask_d;
    logic [NSRC-1:0] edge_s, eligible_s, clr_s;
    logic            irq_q, irq_d;
    logic [2:0]      src_q, src_d, win_s;
    logic [7:0]      vec_q, vec_d;
    logic            found_s;
`ifdef PRIO_ROTATE_EN
    logic [2:0]      ptr_q, ptr_d;
    logic [NSRC-1:0] rot_s;
`endif

    function automatic logic [7:0] vec_of(input logic [2:0] idx);
        return VEC_BASE + 8'(32'(idx) * VEC_STRIDE);
    endfunction

    assign edge_s     = s2_q & ~s3_q;
    assign eligible_s = pending_q & mask_q;
    assign found_s    = |eligible_s;

    // Winner selection among the eligible sources
    always_comb begin
        win_s = 3'd0;
`ifdef PRIO_ROTATE_EN
        rot_s = NSRC'({eligible_s, eligible_s} >> (32'(ptr_q) + 32'd1));
        for (int j = NSRC - 1; j >= 0; j--) begin
            win_s = rot_s[j] ? 3'((32'(ptr_q) + 32'd1 + 32'(j)) % NSRC) : win_s;
        end
`else
        for (int j = NSRC - 1; j >= 0; j--) begin
            win_s = eligible_s[j] ? 3'(j) : win_s;
        end
`endif
    end

    // Handshake FSM next state and pending/mask next values
    always_comb begin
        state_d = state_q;
        irq_d   = irq_q;
        src_d   = src_q;
        vec_d   = vec_q;
        clr_s   = '0;
`ifdef PRIO_ROTATE_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (found_s) begin
                    src_d   = win_s;
                    vec_d   = vec_of(win_s);
                    irq_d   = 1'b1;
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                // ack wins over a simultaneous done; done is simply not looked at here
                if (bus.irq_ack) begin
                    clr_s   = {{(NSRC-1){1'b0}}, 1'b1} << src_q;
                    irq_d   = 1'b0;
                    state_d = SERVICE;
`ifdef PRIO_ROTATE_EN
                    ptr_d   = src_q;
`endif
                end else begin
                    state_d = REQ;
                end
            end
            SERVICE: begin
                if (bus.irq_done) begin
                    state_d = IDLE;
                end else begin
                    state_d = SERVICE;
                end
            end
            default: begin
                state_d = IDLE;
                irq_d   = 1'b0;
            end
        endcase
        // A fresh edge beats the ack clear so a colliding event is not lost
        pending_d = (pending_q & ~clr_s) | edge_s;
        if (bus.mask_we) begin
            mask_d = bus.mask_din;
        end else begin
            mask_d = mask_q;
        end
    end

    // State, synchroniser and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            s1_q      <= '0;
            s2_q      <= '0;
            s3_q      <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            irq_q     <= 1'b0;
            src_q     <= 3'd0;
            vec_q     <= VEC_BASE;
`ifdef PRIO_ROTATE_EN
            ptr_q     <= 3'(NSRC - 1);
`endif
        end else begin
            state_q   <= state_d;
            s1_q      <= bus.src_int;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            irq_q     <= irq_d;
            src_q     <= src_d;
            vec_q     <= vec_d;
`ifdef PRIO_ROTATE_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    assign bus.mask_out    = mask_q;
    assign bus.pending_out = pending_q;
    assign bus.irq         = irq_q;
    assign bus.irq_vec     = vec_q;
    assign bus.irq_src     = src_q;
    assign bus.busy        = (state_q != IDLE);
endmodule
